// File: rtl/led_mode_ctrl_pkg.sv
// Shared encodings for the LED mode sequencer: display modes, bounce direction.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package led_mode_ctrl_pkg;

    // Display modes in the order a mode_next pulse cycles through them.
    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_BLINK  = 2'd1,
        MODE_CHASE  = 2'd2,
        MODE_BOUNCE = 2'd3
    } mode_e;

    // Direction of travel for the lit bit in BOUNCE mode.
    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    // Mode that follows m in the advance order; BOUNCE wraps back to OFF.
    function automatic mode_e next_mode(input mode_e m);
        mode_e nm;
        case (m)
            MODE_OFF:    nm = MODE_BLINK;
            MODE_BLINK:  nm = MODE_CHASE;
            MODE_CHASE:  nm = MODE_BOUNCE;
            MODE_BOUNCE: nm = MODE_OFF;
            default:     nm = MODE_OFF;
        endcase
        return nm;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Free-running step-rate divider: counts 0..TICK_MAX-1, tick in the last count.
// Latency: tick is combinational from the counter register (same cycle).
// Backpressure: hold freezes the count and masks tick; clear restarts from 0.
module led_tick_gen #(
    parameter int unsigned TICK_MAX = 25_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic hold,
    input  logic clear,
    output logic tick
);

    // A divide-by-one still needs a one-bit register to stay well formed.
    localparam int unsigned CNT_W = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             at_last;

    assign at_last = (cnt_q == CNT_LAST);

    // A clear (mode change) overrides both hold and the tick, so the new mode
    // always gets a full period before its first step.
    assign tick = at_last && !hold && !clear;

    // Next count: clear beats hold, hold beats counting, wrap after the last count.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (!hold) begin
            cnt_d = at_last ? '0 : (cnt_q + CNT_ONE);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_mode_ctrl.sv
// LED bank sequencer: four display modes stepped at a fixed tick, pause/advance keys.
// Latency: key pulse sampled at edge N is visible on mode/led/paused from cycle N+1.
// Backpressure: none; pause freezes both the pattern and the tick counter.
module led_mode_ctrl
    import led_mode_ctrl_pkg::*;
#(
    parameter int unsigned TICK_MAX = 25_000_000,
    parameter int unsigned LED_W    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode_next,
    input  logic             pause,
    output logic [LED_W-1:0] led,
    output logic [1:0]       mode,
    output logic             paused,
    output logic             step
);

    localparam logic [LED_W-1:0] LED_LSB = LED_W'(1);

    mode_e            mode_q,   mode_d;
    logic [LED_W-1:0] led_q,    led_d;
    dir_e             dir_q,    dir_d;
    logic             paused_q, paused_d;
    logic             step_q,   step_d;
    logic             tick;

    // Step-rate divider; frozen while paused and restarted on every mode change.
    led_tick_gen #(
        .TICK_MAX (TICK_MAX)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .hold  (paused_q),
        .clear (mode_next),
        .tick  (tick)
    );

    // Mode FSM and pattern update. A mode change loads the entry pattern and
    // swallows any coincident tick; pause toggles independently of both.
    always_comb begin
        mode_d   = mode_q;
        led_d    = led_q;
        dir_d    = dir_q;
        step_d   = 1'b0;
        paused_d = paused_q ^ pause;

        if (mode_next) begin
            mode_d = next_mode(mode_q);
            dir_d  = DIR_LEFT;
            case (mode_d)
                MODE_OFF:    led_d = '0;
                MODE_BLINK:  led_d = '1;
                MODE_CHASE:  led_d = LED_LSB;
                MODE_BOUNCE: led_d = LED_LSB;
                default:     led_d = '0;
            endcase
        end else if (tick) begin
            step_d = 1'b1;
            case (mode_q)
                MODE_OFF: begin
                    led_d = '0;
                end
                MODE_BLINK: begin
                    led_d = ~led_q;
                end
                MODE_CHASE: begin
                    led_d = {led_q[LED_W-2:0], led_q[LED_W-1]};
                end
                MODE_BOUNCE: begin
                    // Turn around as soon as the lit bit lands on an end, so
                    // each end position is displayed for exactly one step.
                    if (dir_q == DIR_LEFT) begin
                        led_d = led_q << 1;
                        if (led_d[LED_W-1]) begin
                            dir_d = DIR_RIGHT;
                        end
                    end else begin
                        led_d = led_q >> 1;
                        if (led_d[0]) begin
                            dir_d = DIR_LEFT;
                        end
                    end
                end
                default: begin
                    led_d = '0;
                end
            endcase
        end
    end

    // State and output registers; reset drops any step in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q   <= MODE_OFF;
            led_q    <= '0;
            dir_q    <= DIR_LEFT;
            paused_q <= 1'b0;
            step_q   <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            led_q    <= led_d;
            dir_q    <= dir_d;
            paused_q <= paused_d;
            step_q   <= step_d;
        end
    end

    assign led    = led_q;
    assign mode   = mode_q;
    assign paused = paused_q;
    assign step   = step_q;

endmodule

// File: doc/led_mode_ctrl.md
Name: led_mode_ctrl

Overview:
Sequencer for the board LED bank. It steps the LEDs through one of four display modes at a fixed tick rate derived from the system clock. A mode-advance pulse and a pause pulse from the key front-end control it, and it drives the LED pins directly. It sits between the debounced key logic and the top-level LED outputs.

Parameters:
TICK_MAX, 25_000_000, clock cycles per display step (0.5 s at 50 MHz); benches override it to 4.
LED_W, 4, number of LEDs driven; must be at least 2.

Ports:
clk  input  1  system clock, 50 MHz.
rst_n  input  1  asynchronous active-low reset.
mode_next  input  1  single-cycle pulse, synchronous and debounced; advances the mode.
pause  input  1  single-cycle pulse, synchronous and debounced; toggles the paused state.
led  output  LED_W  LED drive; 1 = lit.
mode  output  2  current mode: 0 OFF, 1 BLINK, 2 CHASE, 3 BOUNCE.
paused  output  1  1 while stepping is frozen.
step  output  1  single-cycle pulse on every cycle where the pattern advances.

Behaviour:
- Reset (async assert, sync release): mode=0, led=0, paused=0, step=0, tick counter=0, bounce direction=left.
- Tick counter: width is clog2(TICK_MAX).
  - Counts 0..TICK_MAX-1 and wraps to 0.
  - Tick fires in the cycle the counter equals TICK_MAX-1.
  - Counter holds while paused=1.
  - Counter clears to 0 on any mode change, so the first step after entering a mode comes a full TICK_MAX cycles later.
- Mode FSM order: OFF -> BLINK -> CHASE -> BOUNCE -> OFF.
  - mode_next sampled at edge N updates mode and led at edge N. Both outputs are registered, so the new values are visible from cycle N+1.
- Entry patterns, loaded on the mode change:
  - OFF: all 0.
  - BLINK: all 1.
  - CHASE: ...0001.
  - BOUNCE: ...0001 with direction=left.
- Stepping on tick, when not paused:
  - OFF: led stays 0; step still pulses.
  - BLINK: led inverts.
  - CHASE: one-hot rotate left, MSB wraps to LSB.
  - BOUNCE: shift one position in the current direction. Direction flips when the lit bit reaches the MSB (going left) or the LSB (going right). Each end bit is shown for exactly one step. Sequence for LED_W=4: 0001,0010,0100,1000,0100,0010,0001,0010...
- step is registered and asserted for one cycle when led is updated by a tick.
- pause pulse toggles paused.
  - While paused, led and counter freeze.
  - On unpause, counting resumes from the frozen value.
- Simultaneous events:
  - mode_next and tick in the same cycle: the mode change wins, the tick is dropped, step=0.
  - mode_next while paused: the mode changes and the entry pattern loads; paused stays 1.
  - mode_next and pause in the same cycle: both take effect.
- Reset asserted mid-pattern: all state returns to reset values immediately, with no completion of the current step.
- mode_next and pause held high for more than one cycle are treated as repeated pulses; no edge detection is done in this block.

Decomposition:
- Shared package: mode encodings (MODE_OFF/BLINK/CHASE/BOUNCE) and the direction encoding.
- One sub-module, led_tick_gen, containing the parameterised counter.
  - Inputs: clk, rst_n, hold, clear.
  - Output: tick.
- The FSM and pattern registers stay in led_mode_ctrl.

Test Plan:
All scenarios use TICK_MAX=4 and LED_W=4.
1. Reset, then idle 20 cycles -> mode=0, led=0000 throughout; step pulses every 4 cycles.
2. One mode_next pulse -> next cycle mode=1, led=1111; after 4 cycles led=0000, after 8 cycles led=1111, with step high for 1 cycle each time.
3. Two mode_next pulses (CHASE), run 5 ticks -> led 0001,0010,0100,1000,0001,0010.
4. Three mode_next pulses (BOUNCE), run 8 ticks -> led 0001,0010,0100,1000,0100,0010,0001,0010,0100.
5. In CHASE at led=0100, pulse pause, wait 20 cycles -> led stays 0100, step=0, paused=1; pulse pause again -> led=1000 after the remaining counter cycles.
6. Assert mode_next in the same cycle as a tick while in BLINK -> mode=2, led=0001, step=0. Then assert rst_n=0 mid-BOUNCE -> mode=0, led=0000, paused=0 immediately.
